// File: rtl/minized_button_debounce_pkg.sv
// Shared types for the MiniZed push-button debouncer.
package minized_button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } button_state_t;

  // The debounced level is high whenever the accepted state is "pressed".
  function automatic logic is_pressed_state(button_state_t s);
    return (s == PRESSED) || (s == WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/minized_button_debounce_if.sv
// Button-side signal bundle: raw pin and counter clear in, debounced events out.
interface minized_button_debounce_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   button_in;
  logic                   count_clear;
  logic                   button_level;
  logic                   press_pulse;
  logic                   release_pulse;
  logic                   long_press_pulse;
  logic [COUNT_WIDTH-1:0] press_count;

  modport master (
    output button_in, count_clear,
    input  button_level, press_pulse, release_pulse, long_press_pulse, press_count
  );

  modport slave (
    input  button_in, count_clear,
    output button_level, press_pulse, release_pulse, long_press_pulse, press_count
  );
endinterface

// File: rtl/minized_button_debounce_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input; reset value is chosen by the
// caller so that leaving reset does not look like an input edge.
module sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: registered state is always updated with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{RESET_VALUE}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/minized_button_debounce.sv
// Push-button debouncer: synchronizer, 4-state debounce FSM, long-press detection
// and a wrapping press counter, all in the clk domain.
module minized_button_debounce
  import minized_button_pkg::*;
#(
  parameter int   SYNC_STAGES       = 2,
  parameter int   DEBOUNCE_CYCLES   = 1_000_000,
  parameter int   LONG_PRESS_CYCLES = 100_000_000,
  parameter logic ACTIVE_LOW        = 1'b1,
  parameter int   COUNT_WIDTH       = 8
) (
  input logic                      clk,
  input logic                      rst,
  minized_button_debounce_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  // Long press fires on the increment that takes hold_timer to LONG_PRESS_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 2);

  logic sync_out;
  logic pressed;

  button_state_t          state_q, state_d;
  logic [DB_W-1:0]        timer_q, timer_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   level_q;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic [COUNT_WIDTH-1:0] count_q;

  // Reset loads the released pin level so reset exit never produces an edge.
  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.button_in),
    .q   (sync_out)
  );

  assign pressed = sync_out ^ ACTIVE_LOW;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = WAIT_PRESS;
          timer_d = DB_W'(1);
        end
      end
      WAIT_PRESS: begin
        if (!pressed) begin
          state_d = RELEASED;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = PRESSED;
          timer_d = '0;
          hold_d  = '0;
          press_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = WAIT_RELEASE;
          timer_d = DB_W'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
          long_d = (hold_q == HOLD_FIRE);
        end
      end
      WAIT_RELEASE: begin
        // A bounce back to pressed keeps hold_q, so a long press cannot re-fire.
        if (pressed) begin
          state_d = PRESSED;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d   = RELEASED;
          timer_d   = '0;
          release_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RELEASED;
      timer_q   <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      level_q   <= is_pressed_state(state_d);
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // The counter follows the visible press_pulse, so a clear in that same cycle yields 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  count_q <= '0;
    else if (bus.count_clear) count_q <= press_q ? COUNT_WIDTH'(1) : '0;
    else if (press_q)         count_q <= count_q + 1'b1;
  end

  assign bus.button_level     = level_q;
  assign bus.press_pulse      = press_q;
  assign bus.release_pulse    = release_q;
  assign bus.long_press_pulse = long_q;
  assign bus.press_count      = count_q;

endmodule
